uart_rx_fifo: RTL

Receive-side byte buffer placed directly downstream of the UART receiver in the serial top level. It captures each completed byte from the receiver's `rx_data`/`rx_int` pair and queues it in a first-word-fall-through FIFO. It also tracks how many complete CR-terminated lines are queued. Consumers such as the display, the transmit path or a command parser drain it at their own pace, so back-to-back frames are no longer lost.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_fifo_mem.sv | 27 ++
 rtl/uart_rx_fifo.sv | 123 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants: CR code, receive FIFO depth default and baud divisors
// for the 50 MHz system clock.
package uart_pkg;

    localparam logic [7:0]  UART_CR              = 8'h0D;
    localparam int          UART_FIFO_DEPTH_LOG2 = 4;
    localparam int          UART_CLK_HZ          = 50_000_000;
    localparam logic [15:0] UART_DIV_9600        = 16'd5208;
    localparam logic [15:0] UART_DIV_19200       = 16'd2604;
    localparam logic [15:0] UART_DIV_57600       = 16'd868;
    localparam logic [15:0] UART_DIV_115200      = 16'd434;

    function automatic logic is_cr(input logic [7:0] b);
        return (b == UART_CR);
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Register-array storage for the receive FIFO: synchronous write, asynchronous read.
// Contents are deliberately not reset; validity is tracked by the owner's pointers.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = UART_FIFO_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [7:0]            wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [7:0]            rdata
);

    logic [7:0] mem_r [2**DEPTH_LOG2];

    // Store one byte per accepted write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte buffer: captures each completed UART frame into a FWFT FIFO and
// tracks how many CR-terminated lines are queued, with a sticky overflow flag.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = UART_FIFO_DEPTH_LOG2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          rx_data,
    input  logic                rx_int,
    input  logic                rd_en,
    input  logic                clr_ovf,
    output logic [7:0]          rd_data,
    output logic                empty,
    output logic                full,
    output logic [DEPTH_LOG2:0] count,
    output logic [DEPTH_LOG2:0] line_cnt,
    output logic                line_ready,
    output logic                overflow
);

    localparam logic [DEPTH_LOG2:0]   CNT_ZERO = {(DEPTH_LOG2+1){1'b0}};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    logic                  rx_int_d_r;
    logic [DEPTH_LOG2-1:0] wptr_r;
    logic [DEPTH_LOG2-1:0] rptr_r;
    logic [DEPTH_LOG2:0]   count_r;
    logic [DEPTH_LOG2:0]   line_cnt_r;
    logic                  overflow_r;

    logic                  empty_s;
    logic                  full_s;
    logic                  wr_req_s;
    logic                  do_rd_s;
    logic                  do_wr_s;
    logic                  drop_s;
    logic [7:0]            head_s;
    logic [DEPTH_LOG2:0]   count_nxt_s;
    logic [DEPTH_LOG2:0]   line_cnt_nxt_s;
    logic                  overflow_nxt_s;

    assign empty_s  = (count_r == CNT_ZERO);
    assign full_s   = (count_r == CNT_FULL);
    assign wr_req_s = rx_int_d_r & ~rx_int;
    assign do_rd_s  = rd_en & ~empty_s;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
    assign do_wr_s  = wr_req_s & (~full_s | do_rd_s);
    assign drop_s   = wr_req_s & full_s & ~do_rd_s;

    uart_fifo_mem #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem (
        .clk   (clk),
        .wr_en (do_wr_s),
        .waddr (wptr_r),
        .wdata (rx_data),
        .raddr (rptr_r),
        .rdata (head_s)
    );

    // Next-state arithmetic for occupancy, line count and overflow flag.
    always_comb begin
        count_nxt_s    = count_r;
        line_cnt_nxt_s = line_cnt_r;
        overflow_nxt_s = overflow_r;

        case ({do_wr_s, do_rd_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase

        case ({do_wr_s & is_cr(rx_data), do_rd_s & is_cr(head_s)})
            2'b10:   line_cnt_nxt_s = line_cnt_r + CNT_ONE;
            2'b01:   line_cnt_nxt_s = line_cnt_r - CNT_ONE;
            default: line_cnt_nxt_s = line_cnt_r;
        endcase

        if (drop_s) begin
            overflow_nxt_s = 1'b1;
        end else if (clr_ovf) begin
            overflow_nxt_s = 1'b0;
        end else begin
            overflow_nxt_s = overflow_r;
        end
    end

    // Pointer, counter and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_int_d_r <= 1'b0;
            wptr_r     <= {DEPTH_LOG2{1'b0}};
            rptr_r     <= {DEPTH_LOG2{1'b0}};
            count_r    <= CNT_ZERO;
            line_cnt_r <= CNT_ZERO;
            overflow_r <= 1'b0;
        end else begin
            rx_int_d_r <= rx_int;
            if (do_wr_s) begin
                wptr_r <= wptr_r + PTR_ONE;
            end
            if (do_rd_s) begin
                rptr_r <= rptr_r + PTR_ONE;
            end
            count_r    <= count_nxt_s;
            line_cnt_r <= line_cnt_nxt_s;
            overflow_r <= overflow_nxt_s;
        end
    end

    assign rd_data    = empty_s ? 8'h00 : head_s;
    assign empty      = empty_s;
    assign full       = full_s;
    assign count      = count_r;
    assign line_cnt   = line_cnt_r;
    assign line_ready = (line_cnt_r != CNT_ZERO);
    assign overflow   = overflow_r;

endmodule
